// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access size codes, FSM state
// encoding and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_RMW_READ = 2'd2,
    ST_WRITE    = 2'd3
  } lsu_state_t;

  // Size 2'b11 is not a legal access and is always rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = (offset != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane handling over a 32-bit word: load-side extract with
// sign/zero extension, and store-side merge into an existing word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word[7:0];
    case (offset)
      2'd0: byte_sel = rd_word[7:0];
      2'd1: byte_sel = rd_word[15:8];
      2'd2: byte_sel = rd_word[23:16];
      2'd3: byte_sel = rd_word[31:24];
      default: byte_sel = rd_word[7:0];
    endcase
    half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];

    load_data = 32'h0;
    case (size)
      SIZE_BYTE: load_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      SIZE_WORD: load_data = rd_word;
      default:   load_data = 32'h0;
    endcase
  end

  // Only the addressed lane is replaced; the rest of the old word survives.
  always_comb begin
    merged_word = old_word;
    case (size)
      SIZE_BYTE: begin
        case (offset)
          2'd0: merged_word[7:0]   = new_data[7:0];
          2'd1: merged_word[15:8]  = new_data[7:0];
          2'd2: merged_word[23:16] = new_data[7:0];
          2'd3: merged_word[31:24] = new_data[7:0];
          default: merged_word = old_word;
        endcase
      end
      SIZE_HALF: begin
        if (offset[1]) merged_word[31:16] = new_data[15:0];
        else           merged_word[15:0]  = new_data[15:0];
      end
      SIZE_WORD: merged_word = new_data;
      default:   merged_word = old_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-only data memory; byte/half stores are done
// as read-modify-write, loads are lane-extracted and extended.
//
// state       | meaning
// ST_IDLE     | ready for a request; misaligned requests answered from here
// ST_LOAD     | mem_read high, result captured at end of cycle
// ST_RMW_READ | mem_read high, merged word captured at end of cycle
// ST_WRITE    | mem_write high with mem_write_data, then respond
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              res,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misaligned,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_t        state;
  logic [1:0]        size_q;
  logic [1:0]        offset_q;
  logic              unsigned_q;
  logic [DATA_W-1:0] wdata_q;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;

  // Strobes come straight from the state register so a reset kills them at once.
  assign req_ready = (state == ST_IDLE);
  assign mem_read  = (state == ST_LOAD) || (state == ST_RMW_READ);
  assign mem_write = (state == ST_WRITE);

  lsu_lane_align u_lane_align (
    .rd_word     (mem_read_data),
    .offset      (offset_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .old_word    (mem_read_data),
    .new_data    (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state           <= ST_IDLE;
      resp_valid      <= 1'b0;
      resp_misaligned <= 1'b0;
      resp_rdata      <= '0;
      mem_address     <= '0;
      mem_write_data  <= '0;
      size_q          <= 2'b00;
      offset_q        <= 2'b00;
      unsigned_q      <= 1'b0;
      wdata_q         <= '0;
    end else begin
      resp_valid      <= 1'b0;
      resp_misaligned <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            size_q      <= req_size;
            offset_q    <= req_address[1:0];
            unsigned_q  <= req_unsigned;
            wdata_q     <= req_wdata;
            mem_address <= {req_address[ADDR_W-1:2], 2'b00};
            if (is_misaligned(req_size, req_address[1:0])) begin
              resp_valid      <= 1'b1;
              resp_misaligned <= 1'b1;
              resp_rdata      <= '0;
            end else if (!req_store) begin
              state <= ST_LOAD;
            end else if (req_size == SIZE_WORD) begin
              mem_write_data <= req_wdata;
              state          <= ST_WRITE;
            end else begin
              state <= ST_RMW_READ;
            end
          end
        end
        ST_LOAD: begin
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= ST_IDLE;
        end
        ST_RMW_READ: begin
          mem_write_data <= merged_word;
          state          <= ST_WRITE;
        end
        ST_WRITE: begin
          resp_rdata <= '0;
          resp_valid <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word memory model.
module tb_load_store_unit;

  logic        clk;
  logic        res;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:63];

  int n_tests = 0;
  int n_fail  = 0;

  int          lat, nrd, nwr, rdy_busy, ovl_seen, wr_cnt;
  logic [31:0] wr_data, wr_addr, r_data;
  logic        r_mis;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .res             (res),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_store       (req_store),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_address     (req_address),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_read_data   (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_address[7:2]] <= mem_write_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_store    = st;
    req_size     = sz;
    req_unsigned = un;
    req_address  = a;
    req_wdata    = wd;
  endtask

  // Accept edge, then watch up to 8 cycles for the response pulse.
  task automatic collect();
    bit done;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; rdy_busy = 0; done = 0;
    wr_data = 32'hx; wr_addr = 32'hx; r_data = 32'hx; r_mis = 1'bx;
    for (int c = 1; c <= 8 && !done; c++) begin
      @(negedge clk);
      if (mem_read) nrd++;
      if (mem_write) begin nwr++; wr_data = mem_write_data; wr_addr = mem_address; end
      if (mem_read && mem_write) ovl_seen++;
      if (resp_valid) begin
        lat = c; done = 1; r_data = resp_rdata; r_mis = resp_misaligned;
      end else if (req_ready) begin
        rdy_busy++;
      end
    end
  endtask

  task automatic check_resp(input string tag, input int e_lat, input int e_nrd, input int e_nwr,
                            input logic e_mis, input logic [31:0] e_data);
    chk({tag, "_lat"},  32'(lat), 32'(e_lat));
    chk({tag, "_nrd"},  32'(nrd), 32'(e_nrd));
    chk({tag, "_nwr"},  32'(nwr), 32'(e_nwr));
    chk({tag, "_mis"},  {31'h0, r_mis}, {31'h0, e_mis});
    chk({tag, "_data"}, r_data, e_data);
    chk({tag, "_rdy"},  32'(rdy_busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[8]  = 32'h11223344;
    mem[12] = 32'h80F07F01;
    ovl_seen = 0;
    res = 1'b0;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_address = 32'h0; req_wdata = 32'h0;

    #12;
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_mis",        {31'h0, resp_misaligned}, 32'h0);
    chk("rst_strobes",    {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_rdata",      resp_rdata, 32'h0);
    chk("rst_addr",       mem_address, 32'h0);
    chk("rst_wdata",      mem_write_data, 32'h0);
    chk("rst_ready",      {31'h0, req_ready}, 32'h1);
    @(negedge clk) res = 1'b1;

    // Word store then word load.
    @(negedge clk); present(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF); collect();
    check_resp("sw", 2, 0, 1, 1'b0, 32'h0);
    chk("sw_waddr", wr_addr, 32'h10);
    chk("sw_wdata", wr_data, 32'hDEADBEEF);
    @(negedge clk); present(1'b0, 2'b10, 1'b0, 32'h10, 32'h0); collect();
    check_resp("lw", 2, 1, 0, 1'b0, 32'hDEADBEEF);

    // Byte store via read-modify-write; upper wdata bits must be ignored.
    @(negedge clk); present(1'b1, 2'b00, 1'b0, 32'h22, 32'h123456AA); collect();
    check_resp("sb", 3, 1, 1, 1'b0, 32'h0);
    chk("sb_waddr", wr_addr, 32'h20);
    chk("sb_wdata", wr_data, 32'h11AA3344);
    chk("sb_mem",   mem[8], 32'h11AA3344);

    // Lane extraction from 0x80F07F01.
    @(negedge clk); present(1'b0, 2'b00, 1'b0, 32'h32, 32'h0); collect();
    check_resp("lb32s", 2, 1, 0, 1'b0, 32'hFFFFFFF0);
    @(negedge clk); present(1'b0, 2'b00, 1'b1, 32'h32, 32'h0); collect();
    check_resp("lb32u", 2, 1, 0, 1'b0, 32'h000000F0);
    @(negedge clk); present(1'b0, 2'b01, 1'b0, 32'h32, 32'h0); collect();
    check_resp("lh32s", 2, 1, 0, 1'b0, 32'hFFFF80F0);
    @(negedge clk); present(1'b0, 2'b00, 1'b0, 32'h30, 32'h0); collect();
    check_resp("lb30s", 2, 1, 0, 1'b0, 32'h00000001);
    @(negedge clk); present(1'b0, 2'b01, 1'b1, 32'h30, 32'h0); collect();
    check_resp("lh30u", 2, 1, 0, 1'b0, 32'h00007F01);
    @(negedge clk); present(1'b0, 2'b00, 1'b0, 32'h33, 32'h0); collect();
    check_resp("lb33s", 2, 1, 0, 1'b0, 32'hFFFFFF80);

    // Misaligned and illegal-size requests.
    @(negedge clk); present(1'b0, 2'b01, 1'b0, 32'h41, 32'h0); collect();
    check_resp("mis_h41", 1, 0, 0, 1'b1, 32'h0);
    @(negedge clk); present(1'b1, 2'b10, 1'b0, 32'h42, 32'hCAFEF00D); collect();
    check_resp("mis_w42", 1, 0, 0, 1'b1, 32'h0);
    @(negedge clk); present(1'b0, 2'b11, 1'b0, 32'h40, 32'h0); collect();
    check_resp("mis_s11", 1, 0, 0, 1'b1, 32'h0);
    chk("mis_mem", mem[16], 32'h0);

    // Back-to-back: next request presented during each response pulse.
    @(negedge clk); present(1'b1, 2'b10, 1'b0, 32'h50, 32'h12345678); collect();
    check_resp("b2b_sw", 2, 0, 1, 1'b0, 32'h0);
    chk("b2b_rdy1", {31'h0, req_ready}, 32'h1);
    present(1'b1, 2'b01, 1'b0, 32'h52, 32'h0000BEEF); collect();
    check_resp("b2b_sh", 3, 1, 1, 1'b0, 32'h0);
    chk("b2b_sh_wdata", wr_data, 32'hBEEF5678);
    chk("b2b_rdy2", {31'h0, req_ready}, 32'h1);
    present(1'b0, 2'b10, 1'b0, 32'h50, 32'h0); collect();
    check_resp("b2b_lw", 2, 1, 0, 1'b0, 32'hBEEF5678);
    @(negedge clk);
    chk("pulse_single", {31'h0, resp_valid}, 32'h0);
    chk("rdata_hold", resp_rdata, 32'hBEEF5678);
    chk("no_overlap", 32'(ovl_seen), 32'h0);

    // Reset while a byte store is in its read phase.
    present(1'b1, 2'b00, 1'b0, 32'h21, 32'h00000055);
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("rmw_rd_phase", {30'h0, mem_read, mem_write}, 32'h2);
    #2 res = 1'b0;
    #1;
    chk("rr_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rr_valid",   {31'h0, resp_valid}, 32'h0);
    chk("rr_rdata",   resp_rdata, 32'h0);
    chk("rr_addr",    mem_address, 32'h0);
    chk("rr_wdata",   mem_write_data, 32'h0);
    wr_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_write || resp_valid) wr_cnt++;
    end
    chk("rr_quiet", 32'(wr_cnt), 32'h0);
    chk("rr_mem",   mem[8], 32'h11AA3344);
    res = 1'b1;
    @(negedge clk); present(1'b0, 2'b10, 1'b0, 32'h20, 32'h0); collect();
    check_resp("rr_lw", 2, 1, 0, 1'b0, 32'h11AA3344);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the word-addressed data memory interface: accepts load/store requests from the execute stage and drives `mem_read`, `mem_write`, the address and the write data toward data memory.
- Adds byte and halfword access on top of the word-only memory: stores use read-modify-write, loads are lane-extracted and sign/zero-extended.
- Flags misaligned accesses without touching memory.
- Sits between the execute stage and the data memory in the RISC core.

Parameters:
- ADDR_W, 32, width of request and memory address
- DATA_W, 32, data width; fixed 32, word = 4 bytes

Ports:
- clk  input  1  clock, rising edge
- res  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_store  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
- req_address  input  ADDR_W  byte address
- req_wdata  input  DATA_W  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  DATA_W  extended load result; 0 for stores and errors
- resp_misaligned  output  1  valid with resp_valid; access rejected
- mem_read  output  1  read strobe to data memory
- mem_write  output  1  write strobe to data memory
- mem_address  output  ADDR_W  word-aligned address: latched addr[31:2], 2'b00
- mem_write_data  output  DATA_W  full word to write
- mem_read_data  input  DATA_W  combinational read data from memory, same cycle as mem_read

Behaviour:
- Reset (res low, asynchronous):
  - state goes to IDLE.
  - resp_valid, resp_misaligned, mem_read and mem_write go to 0.
  - resp_rdata, mem_address, mem_write_data and the latched request go to 0.
- States: IDLE, LOAD, RMW_READ, WRITE. Strobes are decoded from registered state only:
  - mem_read=1 in LOAD and RMW_READ.
  - mem_write=1 in WRITE.
  - Both strobes are never high together.
- Acceptance:
  - A request is accepted on a rising edge with req_valid && req_ready.
  - All req_* inputs are latched at that edge and ignored afterwards.
- Misalignment: half with addr[0]=1; word with addr[1:0]!=0; any size 11.
  - On accept, the unit stays in IDLE and pulses resp_valid=1, resp_misaligned=1, resp_rdata=0 the next cycle.
  - No strobes are driven.
- Load, aligned:
  - IDLE -> LOAD.
  - At the end of LOAD, the lane selected by addr[1:0] is extracted from mem_read_data.
  - Byte: bits [8k+7:8k], k=addr[1:0]. Half: bits [16k+15:16k], k=addr[1].
  - The result is extended per req_unsigned into resp_rdata, resp_valid=1, -> IDLE.
  - Latency: resp_valid 2 cycles after the accept edge.
- Store word: IDLE -> WRITE.
  - mem_write_data=req_wdata.
  - Memory writes at the WRITE edge, resp_valid next cycle, -> IDLE.
  - Latency: 2 cycles.
- Store byte/half: IDLE -> RMW_READ.
  - At that edge, merge the low byte/half of req_wdata into the selected lane of mem_read_data.
  - Other lanes are kept unchanged. Register the merged word into mem_write_data.
  - -> WRITE -> resp_valid, IDLE.
  - Latency: 3 cycles.
- resp_valid is a single-cycle pulse; there is no back-pressure on responses.
- The resp_valid cycle is in IDLE, so req_ready=1 and a back-to-back accept is legal in that same cycle.
- resp_rdata holds its last value when resp_valid=0.
- Address bits above the memory's index range are passed through unchanged; the unit does no range checking.
- Reset mid-operation: strobes drop immediately. A reset during RMW_READ must not produce any write. The transaction is lost with no response.

Decomposition:
- lsu_pkg holds:
  - Size codes SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10.
  - State encoding.
- One combinational sub-module, lsu_lane_align, provides:
  - extract + extend: inputs word, offset, size, unsigned.
  - merge: inputs old word, new data, offset, size.
- The FSM, latches and strobes stay in load_store_unit.

Test Plan:
- Store word 0xDEADBEEF @0x10, then load word @0x10 -> mem_write pulses 1 cycle with mem_address 0x10; load resp_rdata 0xDEADBEEF, resp_valid 2 cycles after each accept.
- Memory word @0x20 = 0x11223344; store byte 0xAA @0x22 -> one mem_read cycle, then mem_write with data 0x11AA3344; response 3 cycles after accept.
- Memory word @0x30 = 0x80F07F01; loads:
  - byte @0x32 signed -> 0xFFFFFFF0; unsigned -> 0x000000F0.
  - half @0x32 signed -> 0xFFFF80F0.
  - byte @0x30 signed -> 0x00000001.
- Misaligned half @0x41, word @0x42, size 11 @0x40 -> resp_misaligned=1, resp_rdata=0 next cycle; mem_read and mem_write stay 0 throughout.
- Back-to-back: second request held valid during the first response pulse -> accepted in that cycle; strobes never overlap; req_ready low outside IDLE.
- Assert res low during RMW_READ of a byte store -> strobes drop immediately, no mem_write ever, outputs at reset values; after release the next load returns the original memory contents.
